// File: rtl/cpu_alu_seq.sv
// cpu_alu_seq: multi-cycle RV32I ALU; single-cycle logic ops, iterative shifts and low-word multiply
// under a start/busy/done handshake.
module cpu_alu_seq #(
    parameter int DATA_W     = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [3:0]        opcode_i,
    input  logic [DATA_W-1:0] op_a_i,
    input  logic [DATA_W-1:0] op_b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              illegal_o
);
    localparam int SW = $clog2(DATA_W);
    localparam int CW = SW + 1;
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                           OP_XOR = 4'd4, OP_SLT = 4'd5, OP_SLTU = 4'd6, OP_SLL = 4'd7,
                           OP_SRL = 4'd8, OP_SRA = 4'd9, OP_MUL = 4'd10;

    typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;
    state_t state_q, state_d;
    logic [DATA_W-1:0] opd_q, opd_d, mlt_q, mlt_d, acc_q, acc_d, result_q, result_d;
    logic [DATA_W-1:0] alu_res, sh_res;
    logic [CW-1:0]     cnt_q, cnt_d, step;
    logic [3:0]        op_q, op_d;
    logic              done_q, done_d, zero_q, zero_d, ill_q, ill_d;
    logic [SW-1:0]     s;
    logic              accept, is_shift, iterate;

    assign s        = op_b_i[SW-1:0];
    assign accept   = start_i && (state_q == IDLE);
    assign is_shift = opcode_i inside {OP_SLL, OP_SRL, OP_SRA};
    assign iterate  = (opcode_i == OP_MUL) || (is_shift && s != '0);
    assign step     = (cnt_q > CW'(SHIFT_STEP)) ? CW'(SHIFT_STEP) : cnt_q;
    assign sh_res   = (op_q == OP_SLL) ? opd_q << step
                    : (op_q == OP_SRA) ? DATA_W'($signed(opd_q) >>> step)
                    : opd_q >> step;

    // Shifts only reach this path with s=0, where the result is A unchanged.
    always_comb begin
        alu_res = '0;
        case (opcode_i)
            OP_ADD:  alu_res = op_a_i + op_b_i;
            OP_SUB:  alu_res = op_a_i - op_b_i;
            OP_AND:  alu_res = op_a_i & op_b_i;
            OP_OR:   alu_res = op_a_i | op_b_i;
            OP_XOR:  alu_res = op_a_i ^ op_b_i;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(op_a_i) < $signed(op_b_i)};
            OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, op_a_i < op_b_i};
            OP_SLL, OP_SRL, OP_SRA: alu_res = op_a_i;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            opd_q    <= '0;
            mlt_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            zero_q   <= 1'b1;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opd_q    <= opd_d;
            mlt_q    <= mlt_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
            done_q   <= done_d;
            zero_q   <= zero_d;
            ill_q    <= ill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = !accept ? IDLE : (opcode_i == OP_MUL) ? MUL : iterate ? SHIFT : IDLE;
            SHIFT:   state_d = (cnt_q == step) ? IDLE : SHIFT;
            MUL:     state_d = (cnt_q == CW'(1)) ? IDLE : MUL;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        opd_d    = opd_q;
        mlt_d    = mlt_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;
        done_d   = 1'b0;
        ill_d    = ill_q;
        case (state_q)
            IDLE: if (accept) begin
                op_d  = opcode_i;
                opd_d = op_a_i;
                mlt_d = op_b_i;
                acc_d = '0;
                cnt_d = (opcode_i == OP_MUL) ? CW'(DATA_W) : {1'b0, s};
                if (!iterate) begin
                    done_d   = 1'b1;
                    result_d = alu_res;
                    ill_d    = opcode_i > OP_MUL;
                end
            end
            SHIFT: begin
                opd_d = sh_res;
                cnt_d = cnt_q - step;
                if (cnt_q == step) begin
                    done_d   = 1'b1;
                    result_d = sh_res;
                    ill_d    = 1'b0;
                end
            end
            MUL: begin
                acc_d = acc_q + (mlt_q[0] ? opd_q : '0);
                opd_d = opd_q << 1;
                mlt_d = mlt_q >> 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    done_d   = 1'b1;
                    result_d = acc_d;
                    ill_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign zero_d    = (result_d == '0);
    assign busy_o    = (state_q != IDLE);
    assign done_o    = done_q;
    assign result_o  = result_q;
    assign zero_o    = zero_q;
    assign illegal_o = ill_q;
endmodule

// File: doc/cpu_alu_seq.md
# cpu_alu_seq

Parametrised multi-cycle ALU for the RV32I multi-cycle core, replacing the fixed 3-bit, single-cycle ALU opcode set with a 4-bit set that adds XOR, SLTU, the three shifts and a low-word multiply. Single-cycle operations complete in one clock. Shifts and multiply iterate under a start/busy/done handshake, so the control FSM can stall the EXECUTE stage on `busy_o`. Sits between the register-file operand muxes and the ALU-result register in the datapath.

## Interface
- `DATA_W`, 32: operand/result width; power of 2, ≥8.
- `SHIFT_STEP`, 1: maximum bit positions shifted per cycle; power of 2, 1..DATA_W.
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start_i`  in  1  operation request; accepted only when `busy_o`=0.
- `opcode_i`  in  4  operation select; sampled on acceptance.
- `op_a_i`  in  DATA_W  operand A; sampled on acceptance.
- `op_b_i`  in  DATA_W  operand B; sampled on acceptance.
- `busy_o`  out  1  iterative operation in progress.
- `done_o`  out  1  one-cycle pulse: result valid this cycle.
- `result_o`  out  DATA_W  registered result; holds until next completion.
- `zero_o`  out  1  `result_o`==0, registered with it.
- `illegal_o`  out  1  last accepted opcode was unassigned; updated with `done_o`.

## Operation
- Opcodes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101 (signed), SLTU 0110, SLL 0111, SRL 1000, SRA 1001 (sign-fill), MUL 1010 (low DATA_W bits of A*B, sign-agnostic). 1011–1111 are illegal.
- ADD/SUB wrap modulo 2^DATA_W. SLT/SLTU return 1 or 0, zero-extended.
- Shift amount `s` = `op_b_i[$clog2(DATA_W)-1:0]`. Upper bits of B are ignored.
- FSM states: IDLE, SHIFT, MUL.
- IDLE with `start_i`:
  - Single-cycle op, illegal op, or shift with s=0: load result, pulse `done_o`, stay in IDLE. An illegal op sets result to 0 and `illegal_o`=1.
  - Shift with s>0: latch operand and remaining count = s, go to SHIFT.
  - MUL: clear accumulator, latch multiplicand/multiplier, set count = DATA_W, go to MUL.
- SHIFT: each cycle shifts by min(SHIFT_STEP, remaining) and decrements remaining by that amount. When remaining reaches 0, load result, pulse `done_o`, return to IDLE.
- MUL: each cycle, if multiplier LSB = 1, add multiplicand to accumulator. Then shift multiplicand left 1, shift multiplier right 1, decrement count. At count 0, load result, pulse `done_o`, return to IDLE.
- `start_i` while `busy_o`=1 is ignored: no latch, no queueing, in-flight operation unaffected.
- `illegal_o` clears on the next completion of a legal op.

## Timing
- Reset values: `busy_o`=0, `done_o`=0, `result_o`=0, `zero_o`=1, `illegal_o`=0, state IDLE.
- Acceptance happens at the clock edge ending cycle N.
- Single-cycle, illegal, or s=0 shift: `done_o` in cycle N+1. `busy_o` never asserts.
- Shift with s>0: k = ceil(s/SHIFT_STEP). `busy_o` high in cycles N+1..N+k. `done_o` in N+k+1.
- MUL: `busy_o` high in cycles N+1..N+DATA_W. `done_o` in N+DATA_W+1.
- `busy_o` is registered and deasserts in the same cycle `done_o` pulses. A new `start_i` in that cycle is accepted, giving back-to-back operation.
- `result_o`, `zero_o` and `illegal_o` change only in the cycle `done_o` is high.
- Reset asserted mid-operation: immediate return to reset values. The partial result is discarded and no `done_o` is issued.

## Test plan
- Reset then ADD 0x7FFFFFFF+1 (DATA_W=32) → `done_o` at N+1, `result_o`=0x80000000, `zero_o`=0. Then SUB 5-5 back-to-back → next cycle `result_o`=0, `zero_o`=1.
- SLT vs SLTU with A=0xFFFFFFFF, B=1 → SLT gives 1, SLTU gives 0. Both single-cycle.
- SHIFT_STEP=4: SRA A=0x80000000, B=31 → `busy_o` for 8 cycles, `done_o` at N+9, `result_o`=0xFFFFFFFF. SLL with B=0x20 (s=0) → `done_o` at N+1, result = A.
- MUL 0xFFFFFFFF×0xFFFFFFFF → `busy_o` 32 cycles, `done_o` at N+33, result 0x00000001. Pulse `start_i` with ADD during `busy_o` → ignored, result unchanged.
- Opcode 1100 → `done_o` at N+1, `result_o`=0, `illegal_o`=1. Following legal AND → `illegal_o`=0.
- Start MUL, assert `rst_n`=0 at cycle N+10 → all outputs return to reset values immediately, no `done_o`. After release, ADD 2+3 → result 5 at N'+1.
